muldiv_sequencer: RTL and testbench

//  Multi-cycle controller for unsigned multiply/divide, owning the architectural HI/LO registers.

---
 rtl/mips_pkg.sv | 17 +
 rtl/muldiv_step.sv | 39 +++
 rtl/muldiv_sequencer.sv | 117 +++++++++++
 tb/tb_muldiv_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: funct codes for the HI/LO instructions and the
// multiply/divide sequencer state encoding.
package mips_pkg;

   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
   localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
   localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIN  = 2'd3
   } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multi-cycle datapath. This is purely combinational.
// In multiply mode it performs one shift-add step on {hi,lo}, where lo holds
// the remaining multiplier bits. In divide mode it performs one restoring-divide
// step, where hi is the partial remainder and lo is the quotient under construction.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             i_op_div,
   input  logic [WIDTH-1:0] i_hi,
   input  logic [WIDTH-1:0] i_lo,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   logic [WIDTH:0]   w_sum;    // multiply: hi + (lo[0] ? b : 0), carry kept
   logic [WIDTH:0]   w_rsh;    // divide: remainder after shifting in next dividend bit
   logic [WIDTH:0]   w_trial;  // divide: trial subtraction, sign in the top bit
   logic             w_take;   // divide: trial subtraction is non-negative
   logic [WIDTH-1:0] w_mul_hi;
   logic [WIDTH-1:0] w_mul_lo;
   logic [WIDTH-1:0] w_div_hi;
   logic [WIDTH-1:0] w_div_lo;

   assign w_sum    = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : '0);
   assign w_mul_hi = w_sum[WIDTH:1];
   assign w_mul_lo = {w_sum[0], i_lo[WIDTH-1:1]};

   assign w_rsh    = {i_hi, i_lo[WIDTH-1]};
   assign w_trial  = w_rsh - {1'b0, i_b};
   // A set top bit in the shifted remainder guarantees it is >= b.
   assign w_take   = w_rsh[WIDTH] | ~w_trial[WIDTH];
   assign w_div_hi = w_take ? w_trial[WIDTH-1:0] : w_rsh[WIDTH-1:0];
   assign w_div_lo = {i_lo[WIDTH-2:0], w_take};

   assign o_hi = i_op_div ? w_div_hi : w_mul_hi;
   assign o_lo = i_op_div ? w_div_lo : w_mul_lo;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned multiply/divide controller. It owns the architectural HI/LO registers.
// Each operation iterates one bit per cycle through muldiv_step.
// The processor is stalled when it reads HI/LO while an operation is still in flight.
module muldiv_sequencer
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             op_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             rd_req,
   input  logic             rd_hi,
   output logic [WIDTH-1:0] rd_data,
   output logic             stall,
   output logic             busy,
   output logic             done
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   md_state_e        r_state;
   md_state_e        w_state_next;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_hi;      // architectural HI
   logic [WIDTH-1:0] r_lo;      // architectural LO
   logic [WIDTH-1:0] r_phi;     // working upper half (product high / remainder)
   logic [WIDTH-1:0] r_plo;     // working lower half (multiplier / quotient)
   logic [WIDTH-1:0] r_b;       // latched operand b
   logic [WIDTH-1:0] w_step_hi;
   logic [WIDTH-1:0] w_step_lo;
   logic             w_last;

   assign w_last = (r_count == LAST);

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .i_op_div (r_state == DIV),
      .i_hi     (r_phi),
      .i_lo     (r_plo),
      .i_b      (r_b),
      .o_hi     (w_step_hi),
      .o_lo     (w_step_lo)
   );

   // State register.
   // NOTE: every clocked assignment is non-blocking so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_next;
   end

   // Next-state logic. Divide by zero skips iteration and finishes on the next edge.
   // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               if (!op_div)        w_state_next = MUL;
               else if (b == '0)   w_state_next = FIN;
               else                w_state_next = DIV;
            end
         end
         MUL, DIV: if (w_last) w_state_next = FIN;
         FIN:      w_state_next = IDLE;
         default:  w_state_next = IDLE;
      endcase
   end

   // Operand capture, iteration, and HI/LO commit on the edge that enters FIN.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_phi   <= '0;
         r_plo   <= '0;
         r_b     <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_count <= '0;
                  r_phi   <= '0;
                  r_plo   <= a;
                  r_b     <= b;
                  if (op_div && (b == '0)) begin
                     r_hi <= a;
                     r_lo <= '1;
                  end
               end
            end
            MUL, DIV: begin
               r_phi <= w_step_hi;
               r_plo <= w_step_lo;
               if (w_last) begin
                  r_hi <= w_step_hi;
                  r_lo <= w_step_lo;
               end else begin
                  r_count <= r_count + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign busy    = (r_state == MUL) || (r_state == DIV);
   assign done    = (r_state == FIN);
   assign stall   = rd_req & busy;
   assign rd_data = rd_hi ? r_hi : r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer. The stimulus side pushes each expected
// result, with its completion cycle and busy length, when it issues a start.
// The monitor pops an entry and checks it every time done is seen.
`timescale 1ns/1ps
module tb_muldiv_sequencer;

   localparam int W = 32;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           done_cyc;
      int           busy_n;
   } exp_t;

   logic         clk     = 1'b0;
   logic         reset_n = 1'b0;
   logic         start   = 1'b0;
   logic         op_div  = 1'b0;
   logic [W-1:0] a       = '0;
   logic [W-1:0] b       = '0;
   logic         rd_req  = 1'b0;
   logic         stim_hi = 1'b0;
   logic         mon_hi  = 1'b0;
   logic         rd_hi;
   logic [W-1:0] rd_data;
   logic         stall;
   logic         busy;
   logic         done;

   int   cyc      = 0;
   int   checks   = 0;
   int   errors   = 0;
   int   mon_busy = 0;
   exp_t mon_e;
   exp_t sb[$];

   assign rd_hi = stim_hi | mon_hi;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   muldiv_sequencer #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .op_div  (op_div),
      .a       (a),
      .b       (b),
      .rd_req  (rd_req),
      .rd_hi   (rd_hi),
      .rd_data (rd_data),
      .stall   (stall),
      .busy    (busy),
      .done    (done)
   );

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Drive one start pulse. When a result is expected, queue it for the monitor.
   task automatic issue(input logic div, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input bit expect_result);
      exp_t e;
      start  = 1'b1;
      op_div = div;
      a      = aa;
      b      = bb;
      if (expect_result) begin
         e.hi       = eh;
         e.lo       = el;
         e.busy_n   = (div && bb == '0) ? 0 : W;
         e.done_cyc = cyc + ((div && bb == '0) ? 1 : W + 1);
         sb.push_back(e);
      end
      tick();
      start  = 1'b0;
      op_div = 1'b0;
      a      = '0;
      b      = '0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      check({name, "_done_seen"}, {31'b0, done}, 32'd1);
      tick();
   endtask

   // Monitor: count busy cycles, then check each completion against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            mon_busy = 0;
         end else begin
            if (busy) mon_busy++;
            if (done) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done: got done=1 expected no pending result");
               end else begin
                  mon_e = sb.pop_front();
                  check("done_cycle", W'(cyc), W'(mon_e.done_cyc));
                  check("busy_cycles", W'(mon_busy), W'(mon_e.busy_n));
                  check("result_lo", rd_data, mon_e.lo);
                  mon_hi = 1'b1;
                  #0.2;
                  check("result_hi", rd_data, mon_e.hi);
                  mon_hi = 1'b0;
               end
               mon_busy = 0;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      // Reset state
      tick();
      rd_req = 1'b1;
      #1;
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_done", {31'b0, done}, 32'd0);
      check("reset_stall", {31'b0, stall}, 32'd0);
      check("reset_lo", rd_data, 32'd0);
      stim_hi = 1'b1;
      #1;
      check("reset_hi", rd_data, 32'd0);
      stim_hi = 1'b0;
      rd_req  = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();

      // Directed multiply and divide vectors
      issue(1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b1);
      wait_done("mul_7x6");
      issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
      wait_done("mul_max");
      issue(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
      wait_done("div_100_7");
      issue(1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
      wait_done("div_by_zero");
      issue(1'b1, 32'd7, 32'd9, 32'd7, 32'd0, 1'b1);
      wait_done("div_7_9");
      issue(1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b1);
      wait_done("div_max_1");

      // Read while idle returns data immediately, with no stall
      rd_req  = 1'b1;
      stim_hi = 1'b0;
      #1;
      check("idle_rd_stall", {31'b0, stall}, 32'd0);
      check("idle_rd_lo", rd_data, 32'hFFFF_FFFF);
      stim_hi = 1'b1;
      #1;
      check("idle_rd_hi", rd_data, 32'd0);
      stim_hi = 1'b0;
      rd_req  = 1'b0;
      tick();

      // mflo one cycle after multu 3*5 stalls until FIN
      issue(1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b1);
      rd_req = 1'b1;
      #1;
      n = 0;
      while (stall && n < 40) begin
         n++;
         tick();
      end
      check("mflo_stall_cycles", W'(n), W'(32));
      check("mflo_release_done", {31'b0, done}, 32'd1);
      check("mflo_release_data", rd_data, 32'd15);
      rd_req = 1'b0;
      tick();

      // A second start during MUL is ignored
      issue(1'b0, 32'd9, 32'd11, 32'd0, 32'd99, 1'b1);
      repeat (3) tick();
      issue(1'b1, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0);
      repeat (2) tick();
      issue(1'b0, 32'd123, 32'd456, 32'd0, 32'd0, 1'b0);
      wait_done("mul_ignored_start");

      // Leave nonzero HI/LO in place before the abort test
      issue(1'b1, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 1'b1);
      wait_done("div_max_16");

      // Reset in the middle of a divide aborts it and clears HI/LO
      issue(1'b1, 32'd1000, 32'd7, 32'd0, 32'd0, 1'b0);
      repeat (9) tick();
      reset_n = 1'b0;
      #1;
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_lo", rd_data, 32'd0);
      stim_hi = 1'b1;
      #1;
      check("abort_hi", rd_data, 32'd0);
      stim_hi = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      issue(1'b0, 32'd2, 32'd2, 32'd0, 32'd4, 1'b1);
      wait_done("mul_after_abort");

      repeat (5) tick();
      check("scoreboard_drained", W'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
